pe_outport_sink: RTL

//  Receive-side endpoint for a PE data outport. Captures 36-bit tokens from PE_Outport into
//  a FIFO and drives the upstream PE's Post_PE_Bp back-pressure bit (1 = can accept). A

---
 rtl/pe_outport_sink.sv | 83 ++++++++
 1 files changed

// File: rtl/pe_outport_sink.sv
// Receive-side endpoint for a PE data outport: token FIFO, registered back-pressure and a drain port.
// Define PE_SINK_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module pe_outport_sink #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int SKID  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [35:0]   pe_in,
  output logic          post_pe_bp,
  input  logic          rd_en,
  output logic [34:0]   rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [15:0]   tok_cnt,
  output logic          frame_done,
  output logic          ovf
);

  // Handshake: a token moves in when pe_in[35]=1 and a slot is free (a same-cycle pop
  // counts as free); post_pe_bp is only advisory, leaving SKID entries for in-flight tokens.
  // A pop happens when rd_en=1 and the FIFO is not empty; rd_valid marks its data one cycle later.
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] BP_MAX = (AW+1)'(DEPTH - SKID - 1);

  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, accept;
  logic [AW:0]   count_next;

  assign pop    = rd_en && (count != '0);
  assign accept = pe_in[35] && ((count != FULL) || pop);
  assign empty  = (count == '0);

  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + (AW+1)'(1);
    else if (pop && !accept) count_next = count - (AW+1)'(1);
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= pe_in[34:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      post_pe_bp <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      tok_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      count      <= count_next;
      post_pe_bp <= (count_next <= BP_MAX);
      rd_valid   <= pop;
      frame_done <= accept && pe_in[34];
      if (accept) begin
        wptr    <= wptr + AW'(1);
        tok_cnt <= tok_cnt + 16'd1;
      end
      if (pop) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
    end
  end

`ifdef PE_SINK_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ovf <= 1'b0;
    else if (pe_in[35] && !accept) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
